// File: rtl/dsp_skew_buf.sv
// Diagonal input-skew stage for the systolic array: lane i delays by i+1 cycles with sticky FP error flags.
// Optional build macro DSP_SKEW_FTZ_EN flushes accepted denormals to signed zero on entry.
module dsp_skew_buf #(
  parameter int LANES   = 4,
  parameter int EXP_W   = 8,
  parameter int MNTSA_W = 23,
  parameter int FLT_W   = 1 + EXP_W + MNTSA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [LANES*FLT_W-1:0] in_data,
  input  logic [LANES-1:0]       in_dirty,
  input  logic                   err_clr,
  output logic [LANES*FLT_W-1:0] out_data,
  output logic [LANES-1:0]       out_dirty,
  output logic                   err_overflow,
  output logic                   err_underflow,
  output logic                   busy
);

  logic [LANES-1:0] w_ovf_lane;
  logic [LANES-1:0] w_unf_lane;
  logic [LANES-1:0] w_lane_busy;
  logic             r_err_ovf;
  logic             r_err_unf;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [FLT_W-1:0]   w_in;
      logic [EXP_W-1:0]   w_exp;
      logic [MNTSA_W-1:0] w_man;
      logic               w_accept;
      logic               w_denorm;
      logic [FLT_W-1:0]   w_load;
      logic [FLT_W-1:0]   r_data [0:gi];
      logic [gi:0]        r_dirty;

      assign w_in     = in_data[gi*FLT_W +: FLT_W];
      assign w_exp    = w_in[MNTSA_W +: EXP_W];
      assign w_man    = w_in[MNTSA_W-1:0];
      assign w_accept = in_dirty[gi] & ~stall;
      assign w_denorm = (w_exp == '0) && (w_man != '0);

      assign w_ovf_lane[gi] = w_accept & (&w_exp);
      assign w_unf_lane[gi] = w_accept & w_denorm;

      // Bubbles enter as all-zero so idle slots never carry stale operands.
`ifdef DSP_SKEW_FTZ_EN
      assign w_load = !in_dirty[gi] ? '0 :
                      w_denorm      ? {w_in[FLT_W-1], {(FLT_W-1){1'b0}}} : w_in;
`else
      assign w_load = in_dirty[gi] ? w_in : '0;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k <= gi; k++) begin
            r_data[k]  <= '0;
            r_dirty[k] <= 1'b0;
          end
        end else if (!stall) begin
          r_data[0]  <= w_load;
          r_dirty[0] <= in_dirty[gi];
          for (int k = 1; k <= gi; k++) begin
            r_data[k]  <= r_data[k-1];
            r_dirty[k] <= r_dirty[k-1];
          end
        end
      end

      assign out_data[gi*FLT_W +: FLT_W] = r_data[gi];
      assign out_dirty[gi]               = r_dirty[gi];
      assign w_lane_busy[gi]             = |r_dirty;
    end
  endgenerate

  // A new event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else if (!stall) begin
      r_err_ovf <= (|w_ovf_lane) | (r_err_ovf & ~err_clr);
      r_err_unf <= (|w_unf_lane) | (r_err_unf & ~err_clr);
    end
  end

  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;
  assign busy          = |w_lane_busy;

endmodule

// File: tb/tb_dsp_skew_buf.sv
// Self-checking bench for dsp_skew_buf: directed tables, hand sequences and a randomized scoreboard run.
module tb_dsp_skew_buf;
  localparam int L = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, stall, err_clr;
  logic [L*W-1:0] in_data;
  logic [L-1:0]   in_dirty;
  logic [L*W-1:0] out_data;
  logic [L-1:0]   out_dirty;
  logic           err_overflow, err_underflow, busy;

  logic           n_rst, n_stall, n_clr;
  logic [31:0]    n_in_data, n_out_data;
  logic [1:0]     n_in_dirty, n_out_dirty;
  logic           n_ovf, n_unf, n_busy;

  always #5 clk = ~clk;

  dsp_skew_buf #(.LANES(L), .EXP_W(8), .MNTSA_W(23)) dut (
    .clk(clk), .rst(rst), .stall(stall), .in_data(in_data), .in_dirty(in_dirty),
    .err_clr(err_clr), .out_data(out_data), .out_dirty(out_dirty),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .busy(busy)
  );

  dsp_skew_buf #(.LANES(2), .EXP_W(5), .MNTSA_W(10)) dut_n (
    .clk(clk), .rst(n_rst), .stall(n_stall), .in_data(n_in_data), .in_dirty(n_in_dirty),
    .err_clr(n_clr), .out_data(n_out_data), .out_dirty(n_out_dirty),
    .err_overflow(n_ovf), .err_underflow(n_unf), .busy(n_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: history of accepted wavefronts, newest first; lane i shows entry i.
  typedef struct { logic [L*W-1:0] d; logic [L-1:0] v; } wf_t;
  wf_t hist[$];
  bit  m_ovf = 0;
  bit  m_unf = 0;

  function automatic logic [31:0] model_load(input logic [31:0] x, input logic v);
    if (!v) return 32'h0;
`ifdef DSP_SKEW_FTZ_EN
    if (x[30:23] == 8'h00 && x[22:0] != 0) return {x[31], 31'h0};
`endif
    return x;
  endfunction

  task automatic step(input logic [L*W-1:0] d, input logic [L-1:0] v,
                      input bit st, input bit clr, input bit r);
    wf_t            wf;
    bit             ev_o, ev_u, exp_busy;
    logic [L*W-1:0] exp_d;
    logic [L-1:0]   exp_v;
    logic [31:0]    x;
    in_data = d; in_dirty = v; stall = st; err_clr = clr; rst = r;
    @(posedge clk);
    if (r) begin
      hist.delete();
      m_ovf = 0; m_unf = 0;
    end else if (!st) begin
      ev_o = 0; ev_u = 0;
      for (int i = 0; i < L; i++) begin
        x = d[i*W +: W];
        wf.d[i*W +: W] = model_load(x, v[i]);
        if (v[i] && x[30:23] == 8'hFF) ev_o = 1;
        if (v[i] && x[30:23] == 8'h00 && x[22:0] != 0) ev_u = 1;
      end
      wf.v = v;
      m_ovf = ev_o | (m_ovf & !clr);
      m_unf = ev_u | (m_unf & !clr);
      hist.push_front(wf);
      if (hist.size() > L) void'(hist.pop_back());
    end
    #1;
    exp_d = '0; exp_v = '0; exp_busy = 0;
    for (int i = 0; i < L; i++) begin
      if (i < hist.size()) begin
        exp_d[i*W +: W] = hist[i].d[i*W +: W];
        exp_v[i]        = hist[i].v[i];
      end
    end
    for (int k = 0; k < hist.size(); k++)
      for (int i = k; i < L; i++)
        if (hist[k].v[i]) exp_busy = 1;
    chk("sb_out_data", out_data, exp_d);
    chk("sb_out_dirty", out_dirty, exp_v);
    chk("sb_busy", busy, exp_busy);
    chk("sb_err_overflow", err_overflow, m_ovf);
    chk("sb_err_underflow", err_underflow, m_unf);
  endtask

  typedef struct {
    logic [L*W-1:0] d;
    logic [L-1:0]   v;
    bit             clr;
    bit             eo;
    bit             eu;
  } err_vec_t;
  err_vec_t etab[6];

  logic [31:0]    vals [L];
  logic [L*W-1:0] wf_vals;
  logic [L*W-1:0] rd;
  logic [31:0]    lane_v;
  logic [31:0]    exp_ftz;

  initial begin
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000;
    vals[2] = 32'h40400000; vals[3] = 32'h40800000;
    wf_vals = {vals[3], vals[2], vals[1], vals[0]};

    etab[0] = '{d: {32'h0, 32'h7F800000, 32'h0, 32'h0}, v: 4'b0100, clr: 0, eo: 1, eu: 0};
    etab[1] = '{d: {32'h0, 32'h0, 32'h0, 32'h00000001}, v: 4'b0001, clr: 0, eo: 1, eu: 1};
    etab[2] = '{d: {32'h0, 32'h0, 32'h0, 32'h00000001}, v: 4'b0001, clr: 1, eo: 0, eu: 1};
    etab[3] = '{d: '0,                                  v: 4'b0000, clr: 1, eo: 0, eu: 0};
    etab[4] = '{d: {32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000},
                v: 4'b0000, clr: 0, eo: 0, eu: 0};
    etab[5] = '{d: {32'h0, 32'h0, 32'h80000005, 32'h0}, v: 4'b0010, clr: 0, eo: 0, eu: 1};

    n_rst = 1; n_stall = 0; n_clr = 0; n_in_data = '0; n_in_dirty = '0;
    step('0, '0, 0, 0, 1);
    step('0, '0, 0, 0, 1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_dirty", out_dirty, 4'b0);

    // Skew: one wavefront then bubbles.
    step(wf_vals, 4'hF, 0, 0, 0);
    for (int k = 0; k <= L; k++) begin
      if (k > 0) step('0, '0, 0, 0, 0);
      chk("skew_dirty", out_dirty, (k < L) ? (4'b1 << k) : 4'b0);
      if (k < L) chk("skew_data", out_data[k*W +: W], vals[k]);
      chk("skew_busy", busy, k < L);
    end

    // Stall for 3 cycles with garbage inputs offered.
    step(wf_vals, 4'hF, 0, 0, 0);
    for (int s = 0; s < 3; s++) step({4{32'h7F800000}}, 4'hF, 1, 1, 0);
    chk("stall_hold_dirty", out_dirty, 4'b0001);
    chk("stall_hold_data", out_data[31:0], vals[0]);
    chk("stall_no_event", err_overflow, 1'b0);
    for (int k = 1; k <= L; k++) begin
      step('0, '0, 0, 0, 0);
      chk("stall_dirty", out_dirty, (k < L) ? (4'b1 << k) : 4'b0);
      if (k < L) chk("stall_data", out_data[k*W +: W], vals[k]);
    end

    // Reset mid-stream with full chains and an overflow operand at the reset edge.
    for (int s = 0; s < 3; s++) step(wf_vals, 4'hF, 0, 0, 0);
    step({4{32'h7F800000}}, 4'hF, 0, 0, 0);
    step({4{32'h00000001}}, 4'hF, 1, 0, 1);
    chk("rst_data", out_data, '0);
    chk("rst_dirty", out_dirty, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {err_overflow, err_underflow}, 2'b00);
    step('0, '0, 0, 0, 0);
    chk("rst_release_flags", {err_overflow, err_underflow}, 2'b00);

    // Error classification table.
    for (int t = 0; t < 6; t++) begin
      step(etab[t].d, etab[t].v, 0, etab[t].clr, 0);
      chk("err_overflow_tab", err_overflow, etab[t].eo);
      chk("err_underflow_tab", err_underflow, etab[t].eu);
    end
    step('0, '0, 0, 0, 0);
`ifdef DSP_SKEW_FTZ_EN
    exp_ftz = 32'h80000000;
`else
    exp_ftz = 32'h80000005;
`endif
    chk("ftz_lane1", out_data[W +: W], exp_ftz);
    chk("ftz_lane1_dirty", out_dirty, 4'b0010);

    // Randomized run against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      rd = '0;
      for (int i = 0; i < L; i++) begin
        lane_v = $urandom;
        case ($urandom_range(0, 3))
          0: lane_v[30:23] = 8'h7F;
          1: lane_v[30:23] = 8'hFF;
          2: lane_v[30:23] = 8'h00;
          default: lane_v[30:0] = '0;
        endcase
        rd[i*W +: W] = lane_v;
      end
      step(rd, 4'($urandom), ($urandom % 5) == 0, ($urandom % 8) == 0, ($urandom % 40) == 0);
    end
    step('0, '0, 0, 0, 0);
    for (int s = 0; s < L; s++) step('0, '0, 0, 0, 0);
    chk("drain_busy", busy, 1'b0);

    // Narrow 16-bit format, two lanes.
    n_rst = 0; n_in_data = {16'h0001, 16'h7C00}; n_in_dirty = 2'b11;
    @(posedge clk); #1;
    n_in_data = '0; n_in_dirty = '0;
    chk("narrow_ovf", n_ovf, 1'b1);
    chk("narrow_unf", n_unf, 1'b1);
    chk("narrow_dirty0", n_out_dirty, 2'b01);
    chk("narrow_data0", n_out_data[15:0], 16'h7C00);
    @(posedge clk); #1;
    chk("narrow_dirty1", n_out_dirty, 2'b10);
`ifdef DSP_SKEW_FTZ_EN
    chk("narrow_data1", n_out_data[31:16], 16'h0000);
`else
    chk("narrow_data1", n_out_data[31:16], 16'h0001);
`endif
    chk("narrow_busy", n_busy, 1'b1);
    @(posedge clk); #1;
    chk("narrow_drain", {n_busy, n_out_dirty}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dsp_skew_buf.md
# dsp_skew_buf

Parametrised input-skew stage for the DSP systolic array. It takes one wavefront of `LANES` floating-point operands per cycle and delays lane i by i+1 cycles, so row/column operands reach the PE grid diagonally staggered. Each slot carries a dirty (valid) bit. The block also classifies operands on entry into sticky overflow/underflow error flags. Exponent and mantissa widths are parameters, so the same stage serves FP32 and narrower formats.

## Interface

Parameters:
- `LANES`, 4, number of operand lanes (≥1)
- `EXP_W`, 8, exponent width
- `MNTSA_W`, 23, stored mantissa width (hidden leading 1 omitted)
- `FLT_W`, 1+EXP_W+MNTSA_W, element width (derived; do not override)

Ports (ordered sign/exp/mantissa MSB→LSB; lane i occupies bits [i*FLT_W +: FLT_W]):
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  freeze all state; inputs ignored
- `in_data`  in  LANES*FLT_W  wavefront operands
- `in_dirty`  in  LANES  per-lane valid
- `err_clr`  in  1  clear sticky error flags
- `out_data`  out  LANES*FLT_W  skewed operands
- `out_dirty`  out  LANES  per-lane valid of out_data
- `err_overflow`  out  1  sticky: inf/NaN operand accepted
- `err_underflow`  out  1  sticky: denormal operand accepted
- `busy`  out  1  any dirty slot held in any lane

## Operation

- Lane i is a shift chain of i+1 registers, each holding {data, dirty}. Lane 0 has one register, lane LANES-1 has LANES registers. Total slots = LANES*(LANES+1)/2.
- Each non-stalled cycle, every chain shifts by one. Head loads {in_data[i], in_dirty[i]}. out_* is the tail register.
- When in_dirty[i]=0, the data loaded is zero. Bubbles therefore shift as all-zero, non-dirty slots.
- Classification applies to an accepted operand (stall=0, in_dirty[i]=1):
  - exp all ones → overflow event
  - exp all zeros with mantissa ≠ 0 → underflow event
  - ±0 and normal values raise no event
  - Events are OR-reduced over lanes.
- Sticky flags:
  - Set by an event.
  - Cleared by err_clr=1 when stall=0.
  - Event and err_clr in the same cycle: flag ends 1 (set wins).
  - Flags stay unchanged while stall=1.
- busy = OR of all dirty bits in all slots, combinational from registers. Input ports do not feed busy.
- No internal state machine beyond the shift registers and two flag registers.

## Timing

- Latency: operand accepted at edge t on lane i appears on out_data[i] with out_dirty[i]=1 after edge t+i. Lane 0 is visible the cycle after acceptance, lane i is visible i+1 cycles after acceptance.
- Throughput: one wavefront per non-stalled cycle. There is no backpressure other than stall.
- stall=1:
  - every register holds, including flags
  - in_* and err_clr are ignored
  - out_* hold their values
- Drain: with in_dirty=0 held, all lanes are empty and busy=0 after LANES non-stalled cycles.
- Reset (rst=1 at an edge) takes priority over stall and err_clr. It zeroes all slots, out_data, out_dirty, err_overflow, err_underflow and busy. It discards any wavefront in flight and takes effect the cycle after the edge.
- An input cycle with rst=1 is not accepted. Its error events are not recorded.

## Configuration

- `DSP_SKEW_FTZ_EN` defined: flush-to-zero is active. An accepted denormal is loaded as {sign, 0, 0}, i.e. signed zero, and still raises err_underflow.
- `DSP_SKEW_FTZ_EN` undefined: denormals pass unmodified and raise err_underflow.
- All other behaviour is identical in both builds.

## Test plan

- Reset: drive rst=1 mid-stream with LANES=4 chains full, then release → next cycle all out_dirty=0, out_data=0, busy=0, flags=0.
- Skew: LANES=4. Accept one wavefront {1.0, 2.0, 3.0, 4.0} (0x3F800000, 0x40000000, 0x40400000, 0x40800000), then bubbles → out_dirty[i] high for exactly one cycle, lane 0 one cycle after acceptance and lane i i cycles after lane 0, with matching data. busy falls after lane 3 emits.
- Stall: inject a stall of 3 cycles after acceptance → every lane's emission is delayed by exactly 3 cycles, values are unchanged, and inputs presented during the stall are not captured.
- Errors:
  - 0x7F800000 on lane 2 → err_overflow=1 next cycle
  - 0x00000001 on lane 0 → err_underflow=1
  - Repeat the 0x00000001 operand with err_clr=1 in the same cycle → err_underflow stays 1
  - err_clr alone → both flags 0
  - Dirty=0 with 0x7FC00000 raises nothing.
- FTZ: 0x80000005 on lane 1 → with DSP_SKEW_FTZ_EN, out_data[1]=0x80000000; without it, 0x80000005. err_underflow=1 in both builds.
- Narrow format: EXP_W=5, MNTSA_W=10, LANES=2 → 16-bit elements. 0x7C00 sets overflow, 0x0001 sets underflow, and lane 1 latency is 2 cycles.
